axi_slave_mem: RTL and testbench

AXI4 memory-mapped slave with a word-addressed on-chip RAM. It is the downstream consumer of the cache's `M_AXI_*` master port in `top`: it accepts AW/W/AR requests, stores and returns 64-bit data, and generates B/R responses. Write and read channels run independent state machines, so one write burst and one read burst can be in flight at the same time. The block serves as the backing memory in simulation and in FPGA bring-up.

---
 rtl/axi_slave_mem_if.sv | 72 +++++++
 rtl/axi_slave_mem.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_mem_if
// Brief    : AXI4 AW/W/B/AR/R bundle between a master and axi_slave_mem.
// Revision : 1.0
// ============================================================================
interface axi_slave_mem_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID;
  logic [7:0]                  S_AXI_AWLEN;
  logic [2:0]                  S_AXI_AWSIZE;
  logic [1:0]                  S_AXI_AWBURST;
  logic                        S_AXI_AWVALID;
  logic                        S_AXI_AWREADY;

  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                        S_AXI_WLAST;
  logic                        S_AXI_WVALID;
  logic                        S_AXI_WREADY;

  logic [AXI_ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]                  S_AXI_BRESP;
  logic                        S_AXI_BVALID;
  logic                        S_AXI_BREADY;

  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID;
  logic [7:0]                  S_AXI_ARLEN;
  logic [2:0]                  S_AXI_ARSIZE;
  logic [1:0]                  S_AXI_ARBURST;
  logic                        S_AXI_ARVALID;
  logic                        S_AXI_ARREADY;

  logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_RID;
  logic [1:0]                  S_AXI_RRESP;
  logic                        S_AXI_RLAST;
  logic                        S_AXI_RVALID;
  logic                        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_mem
// Brief    : AXI4 slave backed by a word-addressed 64-bit RAM with independent
//            write and read FSMs; SLAVE_RANGE_CHECK_EN enables SLVERR on
//            out-of-range beats (default: addresses alias modulo depth).
// Revision : 1.0
// ============================================================================
module axi_slave_mem #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  axi_slave_mem_if.slave s_axi
);

  localparam int         DEPTH       = 1 << MEM_DEPTH_LOG2;
  localparam int         STRB_W      = AXI_DATA_WIDTH / 8;
  localparam int         WA_W        = AXI_ADDR_WIDTH - 3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
`ifdef SLAVE_RANGE_CHECK_EN
  localparam bit         RANGE_CHECK = 1'b1;
`else
  localparam bit         RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write channel state
  wstate_e                   wstate_q;
  logic [WA_W-1:0]           waddr_q;
  logic [AXI_ID_WIDTH-1:0]   wid_q;
  logic [7:0]                wlen_q;
  logic [1:0]                wburst_q;
  logic [7:0]                wcnt_q;
  logic                      werr_q;
  logic                      awready_q;
  logic                      wready_q;
  logic                      bvalid_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q;
  logic [1:0]                bresp_q;

  // Read channel state
  rstate_e                   rstate_q;
  logic [WA_W-1:0]           raddr_q;
  logic [AXI_ID_WIDTH-1:0]   rid_q;
  logic [7:0]                rlen_q;
  logic [1:0]                rburst_q;
  logic [7:0]                rcnt_q;
  logic                      arready_q;
  logic                      rvalid_q;
  logic                      rlast_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                rresp_q;

  logic                      wr_beat;
  logic                      wr_oob;
  logic [WA_W-1:0]           waddr_d;
  logic [WA_W-1:0]           raddr_d;
  logic                      rd_oob;
  logic [AXI_DATA_WIDTH-1:0] rd_word;
  logic                      unused_sig;

  // Addresses are kept as word addresses; byte offset and size never matter.
  assign wr_beat = (wstate_q == W_DATA) && wready_q && s_axi.S_AXI_WVALID;
  assign wr_oob  = RANGE_CHECK & (|waddr_q[WA_W-1:MEM_DEPTH_LOG2]);
  assign waddr_d = (wburst_q == BURST_FIXED) ? waddr_q : waddr_q + WA_W'(1);

  always_comb begin
    raddr_d = raddr_q;
    if (rstate_q == R_IDLE) begin
      raddr_d = s_axi.S_AXI_ARADDR[AXI_ADDR_WIDTH-1:3];
    end else if (rburst_q != BURST_FIXED) begin
      raddr_d = raddr_q + WA_W'(1);
    end
  end

  assign rd_oob  = RANGE_CHECK & (|raddr_d[WA_W-1:MEM_DEPTH_LOG2]);
  assign rd_word = mem_q[raddr_d[MEM_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (wr_beat && !wr_oob) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) begin
          mem_q[waddr_q[MEM_DEPTH_LOG2-1:0]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wid_q     <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s_axi.S_AXI_AWVALID) begin
            waddr_q   <= s_axi.S_AXI_AWADDR[AXI_ADDR_WIDTH-1:3];
            wid_q     <= s_axi.S_AXI_AWID;
            wlen_q    <= s_axi.S_AXI_AWLEN;
            wburst_q  <= s_axi.S_AXI_AWBURST;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          // Burst length comes from AWLEN alone; WLAST is informational.
          if (wr_beat) begin
            waddr_q <= waddr_d;
            if (wcnt_q == wlen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_q;
              bresp_q  <= (werr_q || wr_oob) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end else begin
              wcnt_q <= wcnt_q + 8'd1;
              werr_q <= werr_q | wr_oob;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s_axi.S_AXI_ARVALID) begin
            raddr_q   <= raddr_d;
            rid_q     <= s_axi.S_AXI_ARID;
            rlen_q    <= s_axi.S_AXI_ARLEN;
            rburst_q  <= s_axi.S_AXI_ARBURST;
            rcnt_q    <= '0;
            rdata_q   <= rd_oob ? '0 : rd_word;
            rresp_q   <= rd_oob ? RESP_SLVERR : RESP_OKAY;
            rlast_q   <= (s_axi.S_AXI_ARLEN == 8'd0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          // The next word is fetched only on a handshake so stalled beats hold.
          if (s_axi.S_AXI_RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              raddr_q <= raddr_d;
              rcnt_q  <= rcnt_q + 8'd1;
              rdata_q <= rd_oob ? '0 : rd_word;
              rresp_q <= rd_oob ? RESP_SLVERR : RESP_OKAY;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BID     = bid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RID     = rid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;

  assign unused_sig = ^{s_axi.S_AXI_AWSIZE, s_axi.S_AXI_ARSIZE, s_axi.S_AXI_WLAST,
                        s_axi.S_AXI_AWADDR[2:0], s_axi.S_AXI_ARADDR[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_mem
// Brief    : Directed + randomized bench for axi_slave_mem against a byte-array
//            memory model (honours SLAVE_RANGE_CHECK_EN when defined).
// Revision : 1.0
// ============================================================================
module tb_axi_slave_mem;

  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int IW     = 4;
  localparam int DL     = 10;
  localparam int NBYTES = (1 << DL) * 8;
`ifdef SLAVE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slave_mem_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

  axi_slave_mem #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MEM_DEPTH_LOG2(DL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  mbyte [NBYTES];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int          rr_mode = 0;
  logic [3:0]  rr_pat  = 4'b1001;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte array, addresses computed arithmetically.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(8 * i);
  endfunction

  function automatic bit oob(input logic [31:0] a);
    return RC && (a >= 32'(NBYTES));
  endfunction

  function automatic int base(input logic [31:0] a);
    return int'((a >> 3) % 32'(1 << DL)) * 8;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    if (!oob(a)) begin
      for (int b = 0; b < 8; b++) if (s[b]) mbyte[base(a) + b] = d[8*b +: 8];
    end
  endtask

  task automatic model_rd(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    if (oob(a)) r = 2'b10;
    else for (int b = 0; b < 8; b++) d[8*b +: 8] = mbyte[base(a) + b];
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit bstall);
    int t;
    bit any_oob;
    any_oob = 1'b0;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWID = id; bus.S_AXI_AWLEN = len;
    bus.S_AXI_AWSIZE = 3'd3; bus.S_AXI_AWBURST = burst; bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    while (bus.S_AXI_AWREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("aw_accept", bus.S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    chk("awready_busy", bus.S_AXI_AWREADY, 0);
    chk("wready_after_aw", bus.S_AXI_WREADY, 1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.S_AXI_WDATA = wd[i]; bus.S_AXI_WSTRB = ws[i];
      bus.S_AXI_WLAST = (i == int'(len)); bus.S_AXI_WVALID = 1'b1;
      t = 0;
      while (bus.S_AXI_WREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      if (t != 0) chk($sformatf("wready_b%0d", i), bus.S_AXI_WREADY, 1);
      @(posedge clk); #1;
      model_wr(beat_addr(addr, burst, i), wd[i], ws[i]);
      any_oob |= oob(beat_addr(addr, burst, i));
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    chk("bvalid_after_last_w", bus.S_AXI_BVALID, 1);
    chk("bid", bus.S_AXI_BID, id);
    chk("bresp", bus.S_AXI_BRESP, any_oob ? 2'b10 : 2'b00);
    if (bstall) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        @(posedge clk); #1;
        chk("bvalid_hold", bus.S_AXI_BVALID, 1);
        chk("bid_hold", bus.S_AXI_BID, id);
      end
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", bus.S_AXI_BVALID, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst);
    int t;
    int i;
    bit rr;
    logic [63:0] ed;
    logic [1:0]  er;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARID = id; bus.S_AXI_ARLEN = len;
    bus.S_AXI_ARSIZE = 3'd3; bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    while (bus.S_AXI_ARREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_accept", bus.S_AXI_ARREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    chk("arready_busy", bus.S_AXI_ARREADY, 0);
    i = 0;
    t = 0;
    while (i <= int'(len) && t < 4 * (int'(len) + 1) + 20) begin
      case (rr_mode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(0, 1));
        default: rr = rr_pat[t % 4];
      endcase
      bus.S_AXI_RREADY = rr;
      model_rd(beat_addr(addr, burst, i), ed, er);
      chk($sformatf("rvalid_b%0d", i), bus.S_AXI_RVALID, 1);
      chk($sformatf("rdata_b%0d", i), bus.S_AXI_RDATA, ed);
      chk($sformatf("rresp_b%0d", i), bus.S_AXI_RRESP, er);
      chk($sformatf("rlast_b%0d", i), bus.S_AXI_RLAST, (i == int'(len)));
      chk($sformatf("rid_b%0d", i), bus.S_AXI_RID, id);
      @(posedge clk); #1;
      t++;
      if (rr) i++;
    end
    bus.S_AXI_RREADY = 1'b0;
    chk("r_beats_done", i, int'(len) + 1);
    chk("rvalid_drop", bus.S_AXI_RVALID, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  bu;
    logic [3:0]  id;
    bit          seen;

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
    bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
    bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.S_AXI_AWREADY, 0);
    chk("rst_wready",  bus.S_AXI_WREADY, 0);
    chk("rst_bvalid",  bus.S_AXI_BVALID, 0);
    chk("rst_arready", bus.S_AXI_ARREADY, 0);
    chk("rst_rvalid",  bus.S_AXI_RVALID, 0);
    chk("rst_rlast",   bus.S_AXI_RLAST, 0);
    chk("rst_bid",     bus.S_AXI_BID, 0);
    chk("rst_bresp",   bus.S_AXI_BRESP, 0);
    chk("rst_rid",     bus.S_AXI_RID, 0);
    chk("rst_rresp",   bus.S_AXI_RRESP, 0);
    chk("rst_rdata",   bus.S_AXI_RDATA, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_awready", bus.S_AXI_AWREADY, 1);
    chk("post_rst_arready", bus.S_AXI_ARREADY, 1);

    // Give every word a known value
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      axi_write(32'(blk * 2048), 4'd0, 8'd255, 2'b01, 1'b0);
    end

    // Single-beat write / read at 0x0
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(32'h0, 4'd0, 8'd0, 2'b01, 1'b0);
    axi_read(32'h0, 4'd0, 8'd0, 2'b01);

    // 4-beat INCR with partial strobe on beat 2
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(8'hA0 + i); ws[i] = 8'hFF; end
    ws[2] = 8'h0F;
    axi_write(32'h40, 4'd1, 8'd3, 2'b01, 1'b1);
    axi_read(32'h40, 4'd1, 8'd3, 2'b01);

    // Stalled read: RREADY 1,0,0,1
    rr_mode = 2;
    axi_read(32'h40, 4'd2, 8'd3, 2'b01);
    rr_mode = 0;

    // Concurrent write (ID 3) and read (ID 5)
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    fork
      axi_write(32'h80, 4'd3, 8'd3, 2'b01, 1'b0);
      axi_read(32'h100, 4'd5, 8'd3, 2'b01);
    join

    // High address: SLVERR with range check, alias to word 0 without
    wd[0] = 64'h5A5A_A5A5_0F0F_F0F0; ws[0] = 8'hFF;
    axi_write(32'h8000_0000, 4'd6, 8'd0, 2'b01, 1'b0);
    axi_read(32'h8000_0000, 4'd6, 8'd0, 2'b01);
    axi_read(32'h0, 4'd7, 8'd0, 2'b01);

    // Randomized bursts, including FIXED/WRAP, unaligned and out-of-range addresses
    for (int n = 0; n < 40; n++) begin
      a  = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000 << $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) a = 32'(NBYTES - 16) + 32'($urandom_range(0, 15));
      l  = 8'($urandom_range(0, 15));
      bu = 2'($urandom_range(0, 2));
      id = 4'($urandom_range(0, 15));
      for (int i = 0; i <= int'(l); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom_range(0, 255)); end
      axi_write(a, id, l, bu, 1'($urandom_range(0, 1)));
      rr_mode = $urandom_range(0, 2);
      axi_read(a, ~id, l, bu);
    end
    rr_mode = 0;

    // Reset in the middle of a write and a read burst
    bus.S_AXI_AWADDR = 32'h200; bus.S_AXI_AWID = 4'd9; bus.S_AXI_AWLEN = 8'd3;
    bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_ARADDR = 32'h300; bus.S_AXI_ARID = 4'd9; bus.S_AXI_ARLEN = 8'd3;
    bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_WDATA = 64'hCAFE_F00D_DEAD_BEEF; bus.S_AXI_WSTRB = 8'hFF; bus.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    model_wr(32'h200, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    bus.S_AXI_WVALID = 1'b0;
    chk("abort_pre_rvalid", bus.S_AXI_RVALID, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_wready", bus.S_AXI_WREADY, 0);
    chk("abort_rvalid", bus.S_AXI_RVALID, 0);
    chk("abort_rdata",  bus.S_AXI_RDATA, 0);
    chk("abort_awready", bus.S_AXI_AWREADY, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_response", seen, 0);
    axi_read(32'h200, 4'd10, 8'd3, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
